arp_resp_ctrl: RTL and testbench

ARP protocol controller on the user side of the ARP rx/tx pair, in the GMII tx clock domain. It answers every received ARP request with an ARP reply and learns sender IP/MAC pairs into a small cache. It also resolves IP addresses to MAC addresses for upper layers: a cache hit answers directly, a miss sends a broadcast ARP request and retries it on timeout. It drives the `arp_tx_en`/`arp_tx_type`/`des_mac`/`des_ip` inputs of the ARP transmitter and consumes `arp_rx_done`/`arp_rx_type`/`src_mac`/`src_ip` from the ARP receiver.

---
 rtl/arp_resp_ctrl_if.sv | 26 ++
 rtl/arp_resp_ctrl.sv | 151 +++++++++++++++
 tb/tb_arp_resp_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/arp_resp_ctrl_if.sv
// arp_resp_ctrl_if: ARP rx/tx/lookup signal bundle; slave = controller view (rx_done/rx_type/src_*/tx_done/lkp_req/lkp_ip in; tx_en/tx_type/des_*/lkp_busy/ack/hit/mac out), master = environment view
interface arp_resp_ctrl_if;
  logic        arp_rx_done;
  logic        arp_rx_type;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic        arp_tx_en;
  logic        arp_tx_type;
  logic [47:0] des_mac;
  logic [31:0] des_ip;
  logic        tx_done;
  logic        lkp_req;
  logic [31:0] lkp_ip;
  logic        lkp_busy;
  logic        lkp_ack;
  logic        lkp_hit;
  logic [47:0] lkp_mac;
  modport master (
    output arp_rx_done, arp_rx_type, src_mac, src_ip, tx_done, lkp_req, lkp_ip,
    input  arp_tx_en, arp_tx_type, des_mac, des_ip, lkp_busy, lkp_ack, lkp_hit, lkp_mac
  );
  modport slave (
    input  arp_rx_done, arp_rx_type, src_mac, src_ip, tx_done, lkp_req, lkp_ip,
    output arp_tx_en, arp_tx_type, des_mac, des_ip, lkp_busy, lkp_ack, lkp_hit, lkp_mac
  );
endinterface

// File: rtl/arp_resp_ctrl.sv
// arp_resp_ctrl: answers ARP requests, learns sender IP/MAC into a cache and resolves lookups (clk, rst, bus = arp_resp_ctrl_if.slave)
module arp_resp_ctrl #(
  parameter int CACHE_DEPTH = 4,
  parameter int TIMEOUT_CYC = 125_000_000,
  parameter int MAX_TRIES   = 3
) (
  input logic           clk,
  input logic           rst,
  arp_resp_ctrl_if.slave bus
);
  localparam int AW = $clog2(CACHE_DEPTH);
  localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam int NW = $clog2(MAX_TRIES + 1);
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;
  typedef enum logic [1:0] {L_IDLE, L_CHECK, L_WAIT} l_state_t;
  logic [CACHE_DEPTH-1:0] c_vld;
  logic [31:0] c_ip [CACHE_DEPTH];
  logic [47:0] c_mac [CACHE_DEPTH];
  logic [AW-1:0] rp;
  logic m_hit, f_inv, c_hit;
  logic [AW-1:0] m_idx, f_idx, w_idx;
  logic [47:0] c_mac_hit;
  logic reply_pend, req_pend;
  logic [47:0] r_mac;
  logic [31:0] r_ip;
  tx_state_t tx_st, tx_nx;
  logic send_rep, send_req;
  l_state_t l_st, l_nx;
  logic [31:0] l_ip;
  logic [TW-1:0] timer;
  logic [NW-1:0] tries;
  logic rx_match, tmo, last, set_req, ack_d, hit_d;
  logic [47:0] mac_d;
  always_comb begin
    m_hit = 1'b0;
    m_idx = '0;
    f_inv = 1'b0;
    f_idx = '0;
    c_hit = 1'b0;
    c_mac_hit = '0;
    for (int i = CACHE_DEPTH - 1; i >= 0; i--) begin
      if (c_vld[i] && c_ip[i] == bus.src_ip) begin
        m_hit = 1'b1;
        m_idx = AW'(i);
      end
      if (!c_vld[i]) begin
        f_inv = 1'b1;
        f_idx = AW'(i);
      end
      if (c_vld[i] && c_ip[i] == l_ip) begin
        c_hit = 1'b1;
        c_mac_hit = c_mac[i];
      end
    end
    w_idx = m_hit ? m_idx : f_inv ? f_idx : rp;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      c_vld <= '0;
      rp <= '0;
    end else if (bus.arp_rx_done) begin
      c_vld[w_idx] <= 1'b1;
      c_ip[w_idx] <= bus.src_ip;
      c_mac[w_idx] <= bus.src_mac;
      if (!m_hit && !f_inv) rp <= rp + AW'(1);
    end
  end
  always_comb begin
    send_rep = tx_st == TX_IDLE && reply_pend;
    send_req = tx_st == TX_IDLE && !reply_pend && req_pend;
    tx_nx = (send_rep || send_req) ? TX_BUSY : (tx_st == TX_BUSY && bus.tx_done) ? TX_IDLE : tx_st;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st <= TX_IDLE;
      reply_pend <= 1'b0;
      req_pend <= 1'b0;
      r_mac <= '0;
      r_ip <= '0;
      bus.arp_tx_en <= 1'b0;
      bus.arp_tx_type <= 1'b0;
      bus.des_mac <= '0;
      bus.des_ip <= '0;
    end else begin
      tx_st <= tx_nx;
      // a request arriving in the launch cycle re-arms the slot for another reply
      reply_pend <= (bus.arp_rx_done && !bus.arp_rx_type) ? 1'b1 : send_rep ? 1'b0 : reply_pend;
      req_pend <= set_req ? 1'b1 : send_req ? 1'b0 : req_pend;
      if (bus.arp_rx_done && !bus.arp_rx_type) begin
        r_mac <= bus.src_mac;
        r_ip <= bus.src_ip;
      end
      bus.arp_tx_en <= send_rep || send_req;
      if (send_rep || send_req) begin
        bus.arp_tx_type <= send_rep;
        bus.des_mac <= send_rep ? r_mac : 48'hFFFF_FFFF_FFFF;
        bus.des_ip <= send_rep ? r_ip : l_ip;
      end
    end
  end
  assign rx_match = bus.arp_rx_done && bus.src_ip == l_ip;
  assign tmo = timer == TW'(TIMEOUT_CYC - 1);
  assign last = tries == NW'(MAX_TRIES);
  assign bus.lkp_busy = l_st != L_IDLE || bus.lkp_ack;
  always_comb begin
    l_nx = l_st;
    ack_d = 1'b0;
    hit_d = 1'b0;
    mac_d = '0;
    set_req = 1'b0;
    case (l_st)
      L_IDLE: l_nx = (bus.lkp_req && !bus.lkp_ack) ? L_CHECK : L_IDLE;
      L_CHECK: begin
        ack_d = c_hit || rx_match;
        hit_d = ack_d;
        mac_d = rx_match ? bus.src_mac : c_mac_hit;
        set_req = !ack_d;
        l_nx = ack_d ? L_IDLE : L_WAIT;
      end
      L_WAIT: begin
        ack_d = rx_match || (tmo && last);
        hit_d = rx_match;
        mac_d = rx_match ? bus.src_mac : '0;
        set_req = !rx_match && tmo && !last;
        l_nx = ack_d ? L_IDLE : L_WAIT;
      end
      default: l_nx = L_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      l_st <= L_IDLE;
      l_ip <= '0;
      timer <= '0;
      tries <= '0;
      bus.lkp_ack <= 1'b0;
      bus.lkp_hit <= 1'b0;
      bus.lkp_mac <= '0;
    end else begin
      l_st <= l_nx;
      if (l_st == L_IDLE && l_nx == L_CHECK) l_ip <= bus.lkp_ip;
      timer <= (l_st == L_WAIT && !set_req) ? timer + TW'(1) : '0;
      tries <= l_st == L_CHECK ? NW'(1) : set_req ? tries + NW'(1) : tries;
      bus.lkp_ack <= ack_d;
      if (ack_d) begin
        bus.lkp_hit <= hit_d;
        bus.lkp_mac <= mac_d;
      end
    end
  end
endmodule

// File: tb/tb_arp_resp_ctrl.sv
// tb_arp_resp_ctrl: directed self-checking bench for arp_resp_ctrl
module tb_arp_resp_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  arp_resp_ctrl_if b ();
  arp_resp_ctrl #(.CACHE_DEPTH(4), .TIMEOUT_CYC(100), .MAX_TRIES(3)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [135:0] outs();
    return {b.arp_tx_en, b.arp_tx_type, b.des_mac, b.des_ip, b.lkp_busy, b.lkp_ack, b.lkp_hit, b.lkp_mac};
  endfunction
  task automatic rx(input logic typ, input logic [31:0] ip, input logic [47:0] mac);
    b.arp_rx_done = 1'b1;
    b.arp_rx_type = typ;
    b.src_ip = ip;
    b.src_mac = mac;
    tick();
    b.arp_rx_done = 1'b0;
  endtask
  task automatic lookup_hit(input string tag, input logic [31:0] ip, input logic [47:0] mac);
    b.lkp_req = 1'b1;
    b.lkp_ip = ip;
    tick();
    b.lkp_req = 1'b0;
    chk({tag, "_busy"}, {b.lkp_busy, b.lkp_ack}, 2'b10);
    tick();
    chk({tag, "_ack"}, {b.lkp_ack, b.lkp_hit, b.lkp_mac, b.lkp_busy, b.arp_tx_en}, {2'b11, mac, 2'b10});
    tick();
    chk({tag, "_done"}, {b.lkp_ack, b.lkp_busy}, 2'b00);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int np, at, nbad_type, seen;
    int pt [3];
    b.arp_rx_done = 1'b0;
    b.arp_rx_type = 1'b0;
    b.src_mac = '0;
    b.src_ip = '0;
    b.tx_done = 1'b0;
    b.lkp_req = 1'b0;
    b.lkp_ip = '0;
    tick();
    tick();
    chk("reset_outs", outs(), '0);
    rst = 1'b0;
    rx(1'b0, 32'hC0A8_0166, 48'h1122_3344_5566);
    chk("reply_n1", b.arp_tx_en, 1'b0);
    tick();
    chk("reply_n2", {b.arp_tx_en, b.arp_tx_type, b.des_mac, b.des_ip}, {2'b11, 48'h1122_3344_5566, 32'hC0A8_0166});
    tick();
    chk("reply_pulse_end", b.arp_tx_en, 1'b0);
    b.tx_done = 1'b1;
    tick();
    b.tx_done = 1'b0;
    lookup_hit("hit66", 32'hC0A8_0166, 48'h1122_3344_5566);
    b.lkp_req = 1'b1;
    b.lkp_ip = 32'hC0A8_0167;
    tick();
    b.lkp_req = 1'b0;
    tick();
    chk("miss_n2", {b.arp_tx_en, b.lkp_ack}, 2'b00);
    tick();
    chk("miss_req_tx", {b.arp_tx_en, b.arp_tx_type, b.des_mac, b.des_ip}, {2'b10, 48'hFFFF_FFFF_FFFF, 32'hC0A8_0167});
    b.tx_done = 1'b1;
    tick();
    b.tx_done = 1'b0;
    for (int i = 0; i < 35; i++) tick();
    chk("wait_busy", {b.lkp_busy, b.lkp_ack}, 2'b10);
    rx(1'b1, 32'hC0A8_0167, 48'hAABB_CCDD_EEFF);
    chk("wait_hit", {b.lkp_ack, b.lkp_hit, b.lkp_mac}, {2'b11, 48'hAABB_CCDD_EEFF});
    tick();
    tick();
    chk("no_reply_for_reply", {b.arp_tx_en, b.lkp_ack}, 2'b00);
    np = 0;
    at = -1;
    nbad_type = 0;
    b.lkp_req = 1'b1;
    b.lkp_ip = 32'hC0A8_0169;
    for (int t = 1; t <= 400; t++) begin
      tick();
      b.lkp_req = 1'b0;
      b.tx_done = 1'b0;
      if (b.arp_tx_en) begin
        if (np < 3) pt[np] = t;
        np++;
        if (b.arp_tx_type !== 1'b0 || b.des_mac !== 48'hFFFF_FFFF_FFFF || b.des_ip !== 32'hC0A8_0169) nbad_type++;
        b.tx_done = 1'b1;
      end
      if (b.lkp_ack) begin
        at = t;
        break;
      end
    end
    b.tx_done = 1'b0;
    chk("tmo_pulses", 136'(np), 136'(3));
    chk("tmo_spacing", {32'(pt[0]), 32'(pt[1]), 32'(pt[2])}, {32'd3, 32'd103, 32'd203});
    chk("tmo_pulse_fields", 136'(nbad_type), '0);
    chk("tmo_ack_cycle", 136'(at), 136'(302));
    chk("tmo_fail", {b.lkp_hit, b.lkp_mac}, '0);
    tick();
    b.lkp_req = 1'b1;
    b.lkp_ip = 32'hC0A8_016A;
    tick();
    b.lkp_req = 1'b0;
    tick();
    tick();
    chk("busy_req_tx", {b.arp_tx_en, b.arp_tx_type}, 2'b10);
    rx(1'b0, 32'hC0A8_0110, 48'h0102_0304_0506);
    rx(1'b0, 32'hC0A8_0111, 48'h0A0B_0C0D_0E0F);
    tick();
    tick();
    tick();
    chk("held_while_busy", b.arp_tx_en, 1'b0);
    b.tx_done = 1'b1;
    tick();
    b.tx_done = 1'b0;
    chk("reply_after_done_n1", b.arp_tx_en, 1'b0);
    tick();
    chk("reply_after_done_n2", {b.arp_tx_en, b.arp_tx_type, b.des_mac, b.des_ip}, {2'b11, 48'h0A0B_0C0D_0E0F, 32'hC0A8_0111});
    b.tx_done = 1'b1;
    tick();
    b.tx_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (b.arp_tx_en) seen++;
    end
    chk("single_reply", 136'(seen), '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) rx(1'b1, 32'h0A00_0000 + 32'(i), 48'(i) * 48'h1111_1111_1111);
    lookup_hit("hit_ip5", 32'h0A00_0005, 48'h5555_5555_5555);
    lookup_hit("hit_ip2", 32'h0A00_0002, 48'h2222_2222_2222);
    b.lkp_req = 1'b1;
    b.lkp_ip = 32'h0A00_0001;
    tick();
    b.lkp_req = 1'b0;
    tick();
    chk("evicted_miss", {b.lkp_ack, b.lkp_busy}, 2'b01);
    tick();
    chk("evicted_req_tx", {b.arp_tx_en, b.des_ip}, {1'b1, 32'h0A00_0001});
    for (int i = 0; i < 5; i++) tick();
    chk("mid_wait_busy", b.lkp_busy, 1'b1);
    rst = 1'b1;
    tick();
    chk("mid_reset_outs", outs(), '0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (b.lkp_ack || b.arp_tx_en || b.lkp_busy) seen++;
    end
    chk("quiet_after_reset", 136'(seen), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
